// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable framing, a runtime baud divisor, a first-word-fall-through
// receive FIFO and sticky framing/parity/overrun flags.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    input  logic                          clr_err,
    output logic                          busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

    state_t               state_q;
    logic                 rxMeta_q, rxS_q, rxPrev_q;
    logic [DIV_W-1:0]     div_q, timer_q;
    logic [IW-1:0]        bitIdx_q;
    logic                 stopIdx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parBad_q, stopBad_q;
    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wrPtr_q, rdPtr_q;
    logic [CW-1:0]        count_q, count_d;
    logic                 frameErr_q, parityErr_q, overrun_q;

    logic tick, rxFall, doPop, doPush, isFull, lastStop, frameBad, expPar;
    logic setFrame, setParity, setOverrun;

    // The timer acts when it reaches 1 so that reloading with div_q gives exactly div_q cycles per bit.
    always_comb begin
        tick       = (timer_q == DIV_W'(1));
        rxFall     = rxPrev_q & ~rxS_q;
        doPop      = rd_en & (count_q != '0);
        isFull     = (count_q == CW'(FIFO_DEPTH));
        lastStop   = (state_q == STOP) && tick && ((STOP_BITS == 1) || stopIdx_q);
        frameBad   = stopBad_q | ~rxS_q;
        expPar     = (PARITY == 2) ? ~(^shift_q) : ^shift_q;
        setFrame   = lastStop & frameBad;
        setParity  = lastStop & ~frameBad & parBad_q;
        setOverrun = lastStop & ~frameBad & ~parBad_q & isFull & ~doPop;
        doPush     = lastStop & ~frameBad & ~parBad_q & (~isFull | doPop);
        count_d    = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + CW'(1);
        end else if (!doPush && doPop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rxMeta_q <= 1'b1;
            rxS_q    <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxS_q    <= rxMeta_q;
            rxPrev_q <= rxS_q;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= IDLE;
            div_q     <= '0;
            timer_q   <= '0;
            bitIdx_q  <= '0;
            stopIdx_q <= 1'b0;
            shift_q   <= '0;
            parBad_q  <= 1'b0;
            stopBad_q <= 1'b0;
        end else begin
            if (timer_q != '0) begin
                timer_q <= timer_q - DIV_W'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (rxFall) begin
                        div_q   <= baud_div;
                        timer_q <= baud_div >> 1;
                        state_q <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (!rxS_q) begin
                            timer_q  <= div_q;
                            bitIdx_q <= '0;
                            state_q  <= DATA;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        timer_q  <= div_q;
                        shift_q  <= {rxS_q, shift_q[DATA_BITS-1:1]};
                        bitIdx_q <= bitIdx_q + IW'(1);
                        if (bitIdx_q == IW'(DATA_BITS - 1)) begin
                            bitIdx_q  <= '0;
                            stopIdx_q <= 1'b0;
                            stopBad_q <= 1'b0;
                            parBad_q  <= 1'b0;
                            state_q   <= (PARITY != 0) ? PAR : STOP;
                        end
                    end
                end
                PAR: begin
                    if (tick) begin
                        timer_q  <= div_q;
                        parBad_q <= (rxS_q != expPar);
                        state_q  <= STOP;
                    end
                end
                STOP: begin
                    if (tick) begin
                        timer_q   <= div_q;
                        stopIdx_q <= 1'b1;
                        if (!rxS_q) begin
                            stopBad_q <= 1'b1;
                        end
                        if (lastStop) begin
                            state_q <= frameBad ? BRK : IDLE;
                        end
                    end
                end
                BRK: begin
                    if (rxS_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge HCLK) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= 8'(shift_q);
        end
    end

    // Set conditions take priority over a coincident clr_err.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            frameErr_q  <= 1'b0;
            parityErr_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            count_q     <= count_d;
            frameErr_q  <= setFrame   | (frameErr_q  & ~clr_err);
            parityErr_q <= setParity  | (parityErr_q & ~clr_err);
            overrun_q   <= setOverrun | (overrun_q   & ~clr_err);
        end
    end

    assign rd_valid   = (count_q != '0);
    assign rd_data    = rd_valid ? mem_q[rdPtr_q] : 8'h00;
    assign fifo_count = count_q;
    assign frame_err  = frameErr_q;
    assign parity_err = parityErr_q;
    assign overrun    = overrun_q;
    assign busy       = (state_q != IDLE);

endmodule
